// File: rtl/multicycle_control.sv
// Multicycle control unit for the 9-bit processor core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with registered,
// phase-by-phase datapath controls, a memory-ready handshake, illegal-opcode
// trapping, a halt state and a saturating retired-instruction counter.
module multicycle_control #(
    parameter int OPW  = 4,
    parameter int AOPW = 4,
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            start,
    input  logic [OPW-1:0]  instr,
    input  logic            mem_ready,
    output logic [AOPW-1:0] ALUOp,
    output logic            MemOrALU,
    output logic            MemWrite,
    output logic            Branch,
    output logic            rd_default,
    output logic            wr_default,
    output logic            ALUsrc1,
    output logic            ALUsrc2,
    output logic            RegWrite,
    output logic            RegWriteSrc,
    output logic            ir_load,
    output logic            pc_en,
    output logic            illegal,
    output logic            done,
    output logic [CNTW-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       mor, mw, br, rdd, wrd, s1, s2, rw, rws;
    } ctrl_t;

    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_EXIT = 4'd7;

    // Full control set of one opcode, as the old single-cycle decoder drove it.
    function automatic ctrl_t decode(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            4'd0, 4'd1: begin c.alu = 4'd0; c.mor = 1'b1; c.wrd = 1'b1; c.rw = 1'b1; end
            4'd2:       begin c.alu = 4'd1; c.mor = 1'b1; c.rdd = 1'b1; c.rw = 1'b1; end
            4'd3:       begin c.alu = 4'd2; c.mor = 1'b1; c.rdd = 1'b1; c.rw = 1'b1; end
            4'd4:       begin c.alu = 4'd3; c.rdd = 1'b1; c.wrd = 1'b1; c.s2 = 1'b1; c.rw = 1'b1; end
            4'd5:       begin c.alu = 4'd4; c.mor = 1'b1; c.wrd = 1'b1; c.s2 = 1'b1; c.rw = 1'b1; end
            4'd6:       begin c.alu = 4'd5; c.mw = 1'b1; c.rdd = 1'b1; c.s2 = 1'b1; end
            4'd8:       begin c.alu = 4'd6; c.br = 1'b1; c.rdd = 1'b1; end
            4'd9:       begin c.alu = 4'd7; c.br = 1'b1; c.rdd = 1'b1; end
            4'd10, 4'd11, 4'd12, 4'd13: begin
                c.alu = op - 4'd2; c.mor = 1'b1; c.wrd = 1'b1; c.s1 = 1'b1; c.rw = 1'b1;
            end
            4'd14, 4'd15: begin c.rw = 1'b1; c.rws = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t         state, next_state;
    logic [OPW-1:0] opcode, next_opcode;
    ctrl_t          cur, nd, q, n;
    logic           legal, next_legal;
    logic           n_ir, n_pc, n_ill, n_done;

    assign cur        = decode(opcode[3:0]);
    assign legal      = (opcode >> 4) == '0;
    assign next_opcode = (state == S_FETCH) ? instr : opcode;
    assign nd         = decode(next_opcode[3:0]);
    assign next_legal = (next_opcode >> 4) == '0;

    // Next-state selection from the current state and latched opcode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = start ? S_FETCH : S_IDLE;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (!legal)                        next_state = S_FETCH;
                else if (opcode[3:0] == OP_EXIT)   next_state = S_HALT;
                else                               next_state = S_EXEC;
            end
            S_EXEC: begin
                if (cur.br)                                               next_state = S_FETCH;
                else if (opcode[3:0] == OP_LW || opcode[3:0] == OP_SW)    next_state = S_MEM;
                else                                                      next_state = S_WB;
            end
            S_MEM: begin
                if (mem_ready) next_state = (opcode[3:0] == OP_SW) ? S_FETCH : S_WB;
            end
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    // Controls the next state will present; registered below so outputs never
    // depend combinationally on inputs. The SW completion pc_en therefore
    // appears in the FETCH cycle that follows the accepted MEM cycle.
    always_comb begin
        n      = '0;
        n_ir   = 1'b0;
        n_pc   = 1'b0;
        n_ill  = 1'b0;
        n_done = 1'b0;
        case (next_state)
            S_FETCH: begin
                n_ir = 1'b1;
                n_pc = (state == S_MEM);
            end
            S_DECODE: begin
                n_ill = !next_legal;
                n_pc  = !next_legal;
            end
            S_EXEC, S_MEM, S_WB: begin
                n.alu = nd.alu;
                n.rdd = nd.rdd;
                n.wrd = nd.wrd;
                n.s1  = nd.s1;
                n.s2  = nd.s2;
                if (next_state == S_EXEC) begin
                    n.br = nd.br;
                    n_pc = nd.br;
                end
                if (next_state == S_MEM) n.mw = nd.mw;
                if (next_state == S_WB) begin
                    n.mor = nd.mor;
                    n.rw  = nd.rw;
                    n.rws = nd.rws;
                    n_pc  = 1'b1;
                end
            end
            S_HALT:  n_done = 1'b1;
            default: n = '0;
        endcase
    end

    // State, latched opcode, registered controls and retired counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_IDLE;
            opcode  <= '0;
            q       <= '0;
            ir_load <= 1'b0;
            pc_en   <= 1'b0;
            illegal <= 1'b0;
            done    <= 1'b0;
            retired <= '0;
        end else begin
            state   <= next_state;
            opcode  <= next_opcode;
            q       <= n;
            ir_load <= n_ir;
            pc_en   <= n_pc;
            illegal <= n_ill;
            done    <= n_done;
            if (pc_en && retired != '1) retired <= retired + 1'b1;
        end
    end

    assign ALUOp       = AOPW'(q.alu);
    assign MemOrALU    = q.mor;
    assign MemWrite    = q.mw;
    assign Branch      = q.br;
    assign rd_default  = q.rdd;
    assign wr_default  = q.wrd;
    assign ALUsrc1     = q.s1;
    assign ALUsrc2     = q.s2;
    assign RegWrite    = q.rw;
    assign RegWriteSrc = q.rws;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (OPW=5, AOPW=5, CNTW=2).
module tb_multicycle_control;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  instr = '0;
    logic        mem_ready = 1'b0;
    logic [4:0]  ALUOp;
    logic        MemOrALU, MemWrite, Branch, rd_default, wr_default;
    logic        ALUsrc1, ALUsrc2, RegWrite, RegWriteSrc;
    logic        ir_load, pc_en, illegal, done;
    logic [1:0]  retired;
    logic [17:0] vec;

    int n_cmp = 0;
    int n_err = 0;

    // Flag positions inside the low 13 bits of vec.
    localparam logic [12:0] MOR = 13'h1000, MW  = 13'h0800, BR  = 13'h0400,
                            RDD = 13'h0200, WRD = 13'h0100, S1  = 13'h0080,
                            S2  = 13'h0040, RW  = 13'h0020, RWS = 13'h0010,
                            IR  = 13'h0008, PC  = 13'h0004, ILL = 13'h0002,
                            DN  = 13'h0001;

    multicycle_control #(.OPW(5), .AOPW(5), .CNTW(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .instr(instr),
        .mem_ready(mem_ready), .ALUOp(ALUOp), .MemOrALU(MemOrALU),
        .MemWrite(MemWrite), .Branch(Branch), .rd_default(rd_default),
        .wr_default(wr_default), .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2),
        .RegWrite(RegWrite), .RegWriteSrc(RegWriteSrc), .ir_load(ir_load),
        .pc_en(pc_en), .illegal(illegal), .done(done), .retired(retired)
    );

    assign vec = {ALUOp, MemOrALU, MemWrite, Branch, rd_default, wr_default,
                  ALUsrc1, ALUsrc2, RegWrite, RegWriteSrc, ir_load, pc_en,
                  illegal, done};

    always #5 Clk = ~Clk;

    function automatic logic [17:0] e(input int alu, input logic [12:0] f);
        return {5'(alu), f};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [17:0] exp);
        check(tag, 32'(vec), 32'(exp));
        tick();
    endtask

    task automatic reset_dut();
        Reset_n = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
        instr = '0;
        #3;
        check("rst_vec", 32'(vec), 32'd0);
        check("rst_cnt", 32'(retired), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    // Leaves the bench at the sample point of the first FETCH cycle.
    task automatic go(input logic [4:0] op);
        instr = op;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // ADD: 4-cycle instruction
        reset_dut();
        go(5'd0);
        cyc("add_fetch", e(0, IR));
        cyc("add_dec",   e(0, 0));
        cyc("add_exec",  e(0, WRD));
        cyc("add_wb",    e(0, MOR | WRD | RW | PC));
        check("add_refetch", 32'(vec), 32'(e(0, IR)));
        check("add_ret", 32'(retired), 32'd1);

        // shl-imm (opcode 12): ALUOp 10
        reset_dut();
        go(5'd12);
        cyc("imm_fetch", e(0, IR));
        cyc("imm_dec",   e(0, 0));
        cyc("imm_exec",  e(10, WRD | S1));
        cyc("imm_wb",    e(10, MOR | WRD | S1 | RW | PC));

        // BRE: 3-cycle instruction
        reset_dut();
        go(5'd8);
        cyc("bre_fetch", e(0, IR));
        cyc("bre_dec",   e(0, 0));
        cyc("bre_exec",  e(6, BR | RDD | PC));
        check("bre_refetch", 32'(vec), 32'(e(0, IR)));
        check("bre_ret", 32'(retired), 32'd1);

        // SW with three wait cycles
        reset_dut();
        go(5'd6);
        cyc("sw_fetch", e(0, IR));
        cyc("sw_dec",   e(0, 0));
        cyc("sw_exec",  e(5, RDD | S2));
        for (int i = 0; i < 3; i++) cyc("sw_mem_wait", e(5, MW | RDD | S2));
        mem_ready = 1'b1;
        cyc("sw_mem_rdy", e(5, MW | RDD | S2));
        mem_ready = 1'b0;
        check("sw_fetch_pc", 32'(vec), 32'(e(0, IR | PC)));
        tick();
        check("sw_dec2", 32'(vec), 32'(e(0, 0)));
        check("sw_ret", 32'(retired), 32'd1);

        // LW with memory ready: 5 cycles
        reset_dut();
        mem_ready = 1'b1;
        go(5'd4);
        cyc("lw_fetch", e(0, IR));
        cyc("lw_dec",   e(0, 0));
        cyc("lw_exec",  e(3, RDD | WRD | S2));
        cyc("lw_mem",   e(3, RDD | WRD | S2));
        cyc("lw_wb",    e(3, RDD | WRD | S2 | RW | PC));
        check("lw_refetch", 32'(vec), 32'(e(0, IR)));
        check("lw_ret", 32'(retired), 32'd1);
        mem_ready = 1'b0;

        // Illegal opcodes: upper bit set, including one whose low bits read EXIT
        reset_dut();
        go(5'b10000);
        cyc("ill_fetch", e(0, IR));
        cyc("ill_dec",   e(0, ILL | PC));
        check("ill_refetch", 32'(vec), 32'(e(0, IR)));
        check("ill_ret", 32'(retired), 32'd1);
        instr = 5'b10111;
        cyc("ill7_fetch", e(0, IR));
        cyc("ill7_dec",   e(0, ILL | PC));
        check("ill7_ret", 32'(retired), 32'd2);

        // ADD then EXIT; start ignored in HALT; reset clears
        reset_dut();
        go(5'd0);
        tick();
        instr = 5'd7;
        tick(); tick(); tick();
        cyc("exit_fetch", e(0, IR));
        cyc("exit_dec",   e(0, 0));
        check("exit_done", 32'(vec), 32'(e(0, DN)));
        start = 1'b1;
        for (int i = 0; i < 3; i++) cyc("halt_hold", e(0, DN));
        start = 1'b0;
        check("halt_ret", 32'(retired), 32'd1);
        Reset_n = 1'b0;
        #2;
        check("halt_rst_vec", 32'(vec), 32'd0);
        check("halt_rst_cnt", 32'(retired), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        check("halt_idle", 32'(vec), 32'd0);

        // Five MOVs saturate the 2-bit counter
        reset_dut();
        go(5'd14);
        cyc("mov_fetch", e(0, IR));
        cyc("mov_dec",   e(0, 0));
        cyc("mov_exec",  e(0, 0));
        cyc("mov_wb",    e(0, RW | RWS | PC));
        check("mov_ret1", 32'(retired), 32'd1);
        repeat (16) tick();
        check("mov_sat", 32'(retired), 32'd3);

        // Reset during an LW memory wait
        reset_dut();
        go(5'd0);
        tick();
        instr = 5'd4;
        repeat (6) tick();
        cyc("lwr_mem", e(3, RDD | WRD | S2));
        check("lwr_mem2", 32'(vec), 32'(e(3, RDD | WRD | S2)));
        check("lwr_ret", 32'(retired), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("lwr_rst_vec", 32'(vec), 32'd0);
        check("lwr_rst_cnt", 32'(retired), 32'd0);
        tick();
        Reset_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc("lwr_idle", e(0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
